emmc_traffic_gen: RTL
=====================

EMMC_TRAFFIC_GEN -- requirements
Module: emmc_traffic_gen

Interface
REQ-001 The block SHALL have parameter DAT_WIDTH, default 8, data bus width in bits (matches jedec_p::DAT_WIDTH).
REQ-002 The block SHALL have parameter WORDS_PER_BLK, default 512, words per eMMC block.
REQ-003 The block SHALL have parameter BLK_CNT_W, default 16, width of the block-count input.
REQ-004 The block SHALL have parameter ERR_W, default 16, width of the error counter.
REQ-005 The block SHALL have parameter SEED, default 'h55, pattern base value.
REQ-006 The block SHALL have parameter LFSR_TAPS, default 'hB8, Galois LFSR tap mask.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset: clk_i in 1 is the clock; rst_i in 1 is the synchronous active-high reset.
REQ-008 The block SHALL have the following control ports:
- run_i in 1: level enable.
- mode_i in 2: pattern select (0 ALT, 1 INC, 2 LFSR, 3 reserved = INC).
- blk_cnt_i in BLK_CNT_W: blocks per operation.
- loops_i in 16: write/read iterations (0 = unlimited).
REQ-009 The block SHALL have the following emmc_sm-side ports:
- we_o out 1: write strobe.
- start_o out 1: start strobe.
- dat_o out DAT_WIDTH: write data.
- blk_cnt_o out BLK_CNT_W: block count.
- dat_i in DAT_WIDTH: read data from emmc_sm.
- dvalid_i in 1: read-data valid from emmc_sm.
- ready_i in 1: ready from emmc_sm.
REQ-010 The block SHALL have the following status outputs:
- busy_o out 1.
- done_o out 1.
- pass_o out 1.
- err_cnt_o out ERR_W.
- first_err_vld_o out 1.
- first_err_idx_o out 32: word index within the operation.
- loop_cnt_o out 16.

Function
REQ-011 FSM states SHALL be IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE, all registered.
REQ-012 IDLE->WR_CMD SHALL occur when run_i=1; mode_i, blk_cnt_i and loops_i latched that cycle; op index k, loop_cnt_o and error state cleared.
REQ-013 In WR_CMD/RD_CMD the block SHALL drive start_o=1 and we_o=1/0 respectively; a cycle with ready_i=1 accepts the command and moves to WR_DATA/RD_DATA next cycle.
REQ-014 Words per op N SHALL equal blk_cnt*WORDS_PER_BLK, with blk_cnt=0 treated as 1; the counter SHALL be 32-bit with no overflow for defaults.
REQ-015 In WR_DATA each cycle with ready_i=1 SHALL consume dat_o, and dat_o SHALL update to word n+1 on the next cycle; after word N-1 is consumed the next state SHALL be RD_CMD.
REQ-016 In RD_DATA each dvalid_i=1 cycle SHALL compare dat_i to expected word n; after word N-1 the block SHALL increment loop_cnt_o and k.
REQ-017 After a read op completes, the next state SHALL be DONE if (loops_i!=0 and loop_cnt_o==loops_i) or run_i=0; otherwise it SHALL be WR_CMD.
REQ-018 run_i=0 mid-op SHALL take effect only at the next read-op boundary (REQ-017); a write op always SHALL be followed by its read.
REQ-019 DONE SHALL hold done_o=1 until run_i=0, then go to IDLE; run_i held high in DONE SHALL NOT restart.
REQ-020 ALT pattern: word = SEED when (n+k) is even, otherwise ~SEED.
REQ-021 INC pattern: word = (n+k) mod 2^DAT_WIDTH.
REQ-022 LFSR pattern: reseeded at n=0 with SEED^k[DAT_WIDTH-1:0] (0 replaced by 1) and advanced once per word; the write and read generators SHALL be independent identical instances.
REQ-023 Each mismatch SHALL increment err_cnt_o, saturating at all-ones.
REQ-024 On the first mismatch since run start, the block SHALL set first_err_vld_o=1 and capture n into first_err_idx_o; these SHALL hold until next run start.
REQ-025 The block SHALL ignore dvalid_i outside RD_DATA and ready_i outside CMD/DATA states.
REQ-026 busy_o SHALL be 1 in all states except IDLE and DONE; pass_o SHALL equal done_o & (err_cnt_o==0); blk_cnt_o SHALL be the latched blk_cnt.

Reset
REQ-027 On rst_i=1 at a clk_i edge, the state SHALL go to IDLE with we_o=0, start_o=0, dat_o=0, blk_cnt_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, first_err_vld_o=0, first_err_idx_o=all-ones and loop_cnt_o=0.
REQ-028 Reset mid-operation SHALL abandon the transfer immediately, with no completion of the current word.

Configuration
REQ-029 Macro EMMC_TRAFFIC_GEN_LFSR_EN defined: the LFSR generators SHALL exist and mode 2 SHALL act per REQ-022.
REQ-030 Macro EMMC_TRAFFIC_GEN_LFSR_EN undefined: no LFSR logic SHALL be synthesized and mode 2 SHALL behave as INC.

Verification
REQ-031 ALT, blk_cnt=2, loops=1, loopback responder -> dat_o 0x55,0xAA,... for 1024 words; done_o=1, pass_o=1, loop_cnt_o=1.
REQ-032 INC, blk_cnt=1, loops=3 -> op k=1 first word 0x01; after 3 loops done_o=1, err_cnt_o=0.
REQ-033 Responder flips bit0 of read word 37 of op 0 -> err_cnt_o=1, first_err_vld_o=1, first_err_idx_o=37, pass_o=0.
REQ-034 ready_i toggling 1-of-3 cycles during WR_DATA -> dat_o stable while ready_i=0; no word skipped or repeated.
REQ-035 run_i dropped mid-WR_DATA with loops=0 -> the read op completes, then DONE; rst_i pulsed mid-RD_DATA -> all REQ-027 values next cycle.
REQ-036 mode 2 with and without EMMC_TRAFFIC_GEN_LFSR_EN -> LFSR sequence seeded 0x55 versus INC sequence 0x00,0x01,...

Source files
------------

// File: rtl/emmc_traffic_gen.sv
// emmc_traffic_gen: pattern traffic generator / checker sitting on top of emmc_sm.
// Each loop writes N = max(blk_cnt,1)*WORDS_PER_BLK words of a pattern, then reads
// them back and compares against an independently regenerated copy of the pattern.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   run_i                 level enable; sampled at start and at read-op boundaries
//   mode_i                pattern: 0 ALT, 1 INC, 2 LFSR (INC if LFSR disabled), 3 INC
//   blk_cnt_i, loops_i    blocks per op, write/read iterations (0 = unlimited)
//   we_o, start_o         command strobes toward emmc_sm (held in CMD states)
//   dat_o                 write data word, advances on each ready_i in WR_DATA
//   blk_cnt_o             latched block count
//   dat_i, dvalid_i       read data from emmc_sm
//   ready_i               command/data accept from emmc_sm
//   busy_o, done_o, pass_o, err_cnt_o, first_err_vld_o, first_err_idx_o, loop_cnt_o
//                         status
//
// Build option: define EMMC_TRAFFIC_GEN_LFSR_EN to include the LFSR generators.
module emmc_traffic_gen #(
    parameter int unsigned DAT_WIDTH     = 8,
    parameter int unsigned WORDS_PER_BLK = 512,
    parameter int unsigned BLK_CNT_W     = 16,
    parameter int unsigned ERR_W         = 16,
    parameter int unsigned SEED          = 'h55,
    parameter int unsigned LFSR_TAPS     = 'hB8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_i,
    input  logic [1:0]           mode_i,
    input  logic [BLK_CNT_W-1:0] blk_cnt_i,
    input  logic [15:0]          loops_i,
    output logic                 we_o,
    output logic                 start_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    output logic [BLK_CNT_W-1:0] blk_cnt_o,
    input  logic [DAT_WIDTH-1:0] dat_i,
    input  logic                 dvalid_i,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_W-1:0]     err_cnt_o,
    output logic                 first_err_vld_o,
    output logic [31:0]          first_err_idx_o,
    output logic [15:0]          loop_cnt_o
);

    localparam int unsigned CNT_W = 32;
    localparam logic [DAT_WIDTH-1:0] SEED_W = DAT_WIDTH'(SEED);
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
    localparam logic [DAT_WIDTH-1:0] TAPS_W = DAT_WIDTH'(LFSR_TAPS);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_RD_CMD,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [15:0]            loop_cnt_q, loop_cnt_d;
    logic [1:0]             mode_q, mode_d;
    logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [15:0]            loops_q, loops_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
    logic                   first_err_vld_q, first_err_vld_d;
    logic [31:0]            first_err_idx_q, first_err_idx_d;
    logic [DAT_WIDTH-1:0]   dat_q, dat_d;
    logic                   we_q, we_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
    logic [DAT_WIDTH-1:0]   wr_lfsr_q, wr_lfsr_d;
    logic [DAT_WIDTH-1:0]   rd_lfsr_q, rd_lfsr_d;
`endif

    logic [BLK_CNT_W-1:0]   blk_eff_c;
    logic [CNT_W-1:0]       last_idx_c;
    logic                   alt_sel_c;
    logic                   lfsr_sel_c;
    logic [DAT_WIDTH-1:0]   rd_exp_c;

    // ALT/INC word for index n of op k; only the parity/low bits of n+k matter
    function automatic logic [DAT_WIDTH-1:0] pat_word(input logic [CNT_W-1:0] n,
                                                      input logic [CNT_W-1:0] k,
                                                      input logic             alt);
        logic [DAT_WIDTH-1:0] s;
        s = DAT_WIDTH'(n) + DAT_WIDTH'(k);
        if (alt) begin
            return s[0] ? ~SEED_W : SEED_W;
        end
        return s;
    endfunction

`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
    // Galois right-shift step
    function automatic logic [DAT_WIDTH-1:0] lfsr_step(input logic [DAT_WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS_W) : (s >> 1);
    endfunction

    // Per-op seed; an all-zero seed would lock the LFSR, so it becomes 1
    function automatic logic [DAT_WIDTH-1:0] lfsr_seed(input logic [CNT_W-1:0] k);
        logic [DAT_WIDTH-1:0] s;
        s = SEED_W ^ DAT_WIDTH'(k);
        return (s == '0) ? DAT_WIDTH'(1) : s;
    endfunction
`endif

    // Words per op: blk_cnt 0 behaves as 1 block
    assign blk_eff_c  = (blk_cnt_q == '0) ? BLK_CNT_W'(1) : blk_cnt_q;
    assign last_idx_c = (CNT_W'(blk_eff_c) * CNT_W'(WORDS_PER_BLK)) - CNT_W'(1);
    assign alt_sel_c  = (mode_q == 2'd0);
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
    assign lfsr_sel_c = (mode_q == 2'd2);
    assign rd_exp_c   = lfsr_sel_c ? rd_lfsr_q : pat_word(n_q, k_q, alt_sel_c);
`else
    assign lfsr_sel_c = 1'b0;
    assign rd_exp_c   = pat_word(n_q, k_q, alt_sel_c);
`endif

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        k_d             = k_q;
        loop_cnt_d      = loop_cnt_q;
        mode_d          = mode_q;
        blk_cnt_d       = blk_cnt_q;
        loops_d         = loops_q;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_idx_d = first_err_idx_q;
        dat_d           = dat_q;
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
        wr_lfsr_d       = wr_lfsr_q;
        rd_lfsr_d       = rd_lfsr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d         = S_WR_CMD;
                    mode_d          = mode_i;
                    blk_cnt_d       = blk_cnt_i;
                    loops_d         = loops_i;
                    n_d             = '0;
                    k_d             = '0;
                    loop_cnt_d      = '0;
                    err_cnt_d       = '0;
                    first_err_vld_d = 1'b0;
                    first_err_idx_d = '1;
                end
            end
            S_WR_CMD: begin
                if (ready_i) begin
                    state_d = S_WR_DATA;
                    n_d     = '0;
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
                    wr_lfsr_d = lfsr_seed(k_q);
`endif
                end
            end
            S_WR_DATA: begin
                if (ready_i) begin
                    if (n_q == last_idx_c) begin
                        state_d = S_RD_CMD;
                        n_d     = '0;
                    end else begin
                        n_d = n_q + CNT_W'(1);
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
                        wr_lfsr_d = lfsr_step(wr_lfsr_q);
`endif
                    end
                end
            end
            S_RD_CMD: begin
                if (ready_i) begin
                    state_d = S_RD_DATA;
                    n_d     = '0;
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
                    rd_lfsr_d = lfsr_seed(k_q);
`endif
                end
            end
            S_RD_DATA: begin
                if (dvalid_i) begin
                    if (dat_i != rd_exp_c) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (!first_err_vld_q) begin
                            first_err_vld_d = 1'b1;
                            first_err_idx_d = n_q;
                        end
                    end
                    if (n_q == last_idx_c) begin
                        n_d        = '0;
                        k_d        = k_q + CNT_W'(1);
                        loop_cnt_d = loop_cnt_q + 16'd1;
                        // run_i is only honoured here, at the end of a read op
                        if (((loops_q != 16'd0) && (loop_cnt_d == loops_q)) || !run_i) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WR_CMD;
                        end
                    end else begin
                        n_d = n_q + CNT_W'(1);
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
                        rd_lfsr_d = lfsr_step(rd_lfsr_q);
`endif
                    end
                end
            end
            S_DONE: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Present word n_d on dat_o whenever WR_DATA is (still) the next state
        if (state_d == S_WR_DATA) begin
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
            dat_d = lfsr_sel_c ? wr_lfsr_d : pat_word(n_d, k_d, alt_sel_c);
`else
            dat_d = pat_word(n_d, k_d, alt_sel_c);
`endif
        end

        we_d    = (state_d == S_WR_CMD);
        start_d = (state_d == S_WR_CMD) || (state_d == S_RD_CMD);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        pass_d  = done_d && (err_cnt_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            n_q             <= '0;
            k_q             <= '0;
            loop_cnt_q      <= '0;
            mode_q          <= '0;
            blk_cnt_q       <= '0;
            loops_q         <= '0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '1;
            dat_q           <= '0;
            we_q            <= 1'b0;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
            wr_lfsr_q       <= SEED_W;
            rd_lfsr_q       <= SEED_W;
`endif
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            k_q             <= k_d;
            loop_cnt_q      <= loop_cnt_d;
            mode_q          <= mode_d;
            blk_cnt_q       <= blk_cnt_d;
            loops_q         <= loops_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_idx_q <= first_err_idx_d;
            dat_q           <= dat_d;
            we_q            <= we_d;
            start_q         <= start_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
`ifdef EMMC_TRAFFIC_GEN_LFSR_EN
            wr_lfsr_q       <= wr_lfsr_d;
            rd_lfsr_q       <= rd_lfsr_d;
`endif
        end
    end

    assign we_o            = we_q;
    assign start_o         = start_q;
    assign dat_o           = dat_q;
    assign blk_cnt_o       = blk_cnt_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_vld_o = first_err_vld_q;
    assign first_err_idx_o = first_err_idx_q;
    assign loop_cnt_o      = loop_cnt_q;

endmodule
